mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch I, load/store D) arbiter in front of mem_bus.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of strict D-over-I.
module mem_arbiter #(
    parameter int address_size = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [address_size-1:0] i_addr,
    input  logic [2:0]              i_num_bytes,
    output logic                    i_done,
    output logic [31:0]             i_rdata,
    input  logic                    d_req,
    input  logic [address_size-1:0] d_addr,
    input  logic                    d_is_write,
    input  logic [31:0]             d_wdata,
    input  logic [2:0]              d_num_bytes,
    output logic                    d_done,
    output logic [31:0]             d_rdata,
    output logic                    bus_start_request,
    output logic [address_size-1:0] bus_target_address,
    output logic                    bus_is_write,
    output logic [31:0]             bus_write_value,
    output logic [2:0]              bus_num_bytes,
    input  logic                    bus_request_done,
    input  logic [31:0]             bus_fetched_value,
    output logic                    grant_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state_q;
    logic   pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_grant_q = 1 means D won the previous arbitration.
    logic last_grant_q;
    assign pick_d = d_req && (!i_req || !last_grant_q);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            bus_start_request  <= 1'b0;
            bus_target_address <= '0;
            bus_is_write       <= 1'b0;
            bus_write_value    <= '0;
            bus_num_bytes      <= '0;
            grant_d            <= 1'b0;
            i_done             <= 1'b0;
            d_done             <= 1'b0;
            i_rdata            <= '0;
            d_rdata            <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q       <= 1'b1;
`endif
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_req || i_req) begin
                        bus_start_request <= 1'b1;
                        grant_d           <= pick_d;
                        state_q           <= BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_q      <= pick_d;
`endif
                        if (pick_d) begin
                            bus_target_address <= d_addr;
                            bus_is_write       <= d_is_write;
                            bus_write_value    <= d_wdata;
                            bus_num_bytes      <= d_num_bytes;
                        end else begin
                            // Port I is fetch-only, so it never issues a write.
                            bus_target_address <= i_addr;
                            bus_is_write       <= 1'b0;
                            bus_write_value    <= '0;
                            bus_num_bytes      <= i_num_bytes;
                        end
                    end
                end
                BUSY: begin
                    if (bus_request_done) begin
                        bus_start_request <= 1'b0;
                        state_q           <= RELEASE;
                        if (grant_d) begin
                            d_rdata <= bus_fetched_value;
                            d_done  <= 1'b1;
                        end else begin
                            i_rdata <= bus_fetched_value;
                            i_done  <= 1'b1;
                        end
                    end
                end
                // Low start_request gap lets mem_bus return to its parse state.
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, reset/contention/back-to-back sequences,
// and a scoreboard queue of expected {port, rdata} completions.
module tb_mem_arbiter;

    localparam int AW = 18;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_is_write, i_done, d_done;
    logic [AW-1:0] i_addr, d_addr, bus_target_address;
    logic [2:0]    i_num_bytes, d_num_bytes, bus_num_bytes;
    logic [31:0]   i_rdata, d_rdata, d_wdata, bus_write_value, bus_fetched_value;
    logic          bus_start_request, bus_is_write, bus_request_done, grant_d;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];
    logic prev_done = 1'b0;
    logic model_last_d = 1'b1;
    logic [31:0] last_i_rv = '0;

    typedef struct {
        logic          is_d;
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   wdata;
        logic [2:0]    nb;
        int            lat;
        logic [31:0]   rv;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    mem_arbiter #(.address_size(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_num_bytes(i_num_bytes),
        .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_is_write(d_is_write), .d_wdata(d_wdata),
        .d_num_bytes(d_num_bytes), .d_done(d_done), .d_rdata(d_rdata),
        .bus_start_request(bus_start_request), .bus_target_address(bus_target_address),
        .bus_is_write(bus_is_write), .bus_write_value(bus_write_value),
        .bus_num_bytes(bus_num_bytes), .bus_request_done(bus_request_done),
        .bus_fetched_value(bus_fetched_value), .grant_d(grant_d)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst && (i_done || d_done)) begin
            chk("done_width", 64'(prev_done), 64'd0);
            chk("done_both", 64'(i_done & d_done), 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("done_port", 64'(d_done), 64'(e[32]));
                chk("done_rdata", 64'(d_done ? d_rdata : i_rdata), 64'(e[31:0]));
            end
        end
        prev_done = i_done | d_done;
    end

    task automatic wait_start(output int n);
        n = 0;
        while (!bus_start_request && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Hold the bus busy for lat cycles, then return rv; ends in the done cycle.
    task automatic finish_txn(input int lat, input logic [31:0] rv);
        logic [AW-1:0] a0;
        logic [31:0]   w0;
        logic          wr0, g0;
        logic [2:0]    nb0;
        int            bad;
        a0 = bus_target_address; w0 = bus_write_value; wr0 = bus_is_write;
        nb0 = bus_num_bytes; g0 = grant_d; bad = 0;
        repeat (lat) begin
            tick();
            if (bus_target_address !== a0 || bus_write_value !== w0 || bus_is_write !== wr0 ||
                bus_num_bytes !== nb0 || grant_d !== g0 || bus_start_request !== 1'b1)
                bad++;
        end
        chk("bus_stable", 64'(bad), 64'd0);
        bus_fetched_value = rv;
        bus_request_done  = 1'b1;
        exp_q.push_back({g0, rv});
        tick();
        bus_request_done  = 1'b0;
        bus_fetched_value = $urandom;
        chk("start_drop", 64'(bus_start_request), 64'd0);
        chk("release_state", 64'(dut.state_q), 64'(ST_RELEASE));
    endtask

    // Serve ntx arbitrations with whatever reqs are raised; winner drops req in its done cycle.
    task automatic contend(input int ntx, input logic rearm);
        int n;
        logic exp_d;
        for (int k = 0; k < ntx; k++) begin
            wait_start(n);
            chk("gap_latency", 64'(n), 64'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = d_req && (!i_req || !model_last_d);
`else
            exp_d = d_req;
`endif
            model_last_d = exp_d;
            chk("contend_grant", 64'(grant_d), 64'(exp_d));
            chk("contend_addr", 64'(bus_target_address), 64'(exp_d ? d_addr : i_addr));
            finish_txn(1, 32'hC0DE_0000 + 32'(k));
            if (exp_d) d_req = 1'b0; else i_req = 1'b0;
            tick();
            chk("idle_low", 64'({dut.state_q, bus_start_request}), 64'({ST_IDLE, 1'b0}));
            if (rearm) begin
                if (exp_d) d_req = 1'b1; else i_req = 1'b1;
            end
            if (!exp_d) last_i_rv = 32'hC0DE_0000 + 32'(k);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; i_req = 0; d_req = 0; d_is_write = 0; i_addr = '0; d_addr = '0;
        i_num_bytes = '0; d_num_bytes = '0; d_wdata = '0;
        bus_request_done = 0; bus_fetched_value = '0;
        repeat (3) tick();
        chk("rst_start", 64'(bus_start_request), 64'd0);
        chk("rst_bus", 64'({bus_is_write, bus_target_address, bus_num_bytes}), 64'd0);
        chk("rst_wval", 64'(bus_write_value), 64'd0);
        chk("rst_done", 64'({i_done, d_done, grant_d}), 64'd0);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        rst = 1'b0;
        model_last_d = 1'b1;
        tick();

        vecs[0] = '{1'b0, 18'h00040, 1'b0, 32'h0,         3'd4, 10, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 18'h20010, 1'b1, 32'h1,         3'd4, 3,  32'hFFFF0000};
        vecs[2] = '{1'b1, 18'h10000, 1'b0, 32'h0,         3'd2, 0,  32'h1234ABCD};
        vecs[3] = '{1'b0, 18'h3FFFF, 1'b0, 32'h0,         3'd1, 1,  32'hCAFEF00D};
        vecs[4] = '{1'b1, 18'h00000, 1'b1, 32'($urandom), 3'd3, int'($urandom_range(2, 6)), 32'($urandom)};

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].is_d) begin
                d_req = 1; d_addr = vecs[v].addr; d_is_write = vecs[v].wr;
                d_wdata = vecs[v].wdata; d_num_bytes = vecs[v].nb;
            end else begin
                i_req = 1; i_addr = vecs[v].addr; i_num_bytes = vecs[v].nb;
                d_is_write = 1'b1; d_wdata = $urandom;
            end
            wait_start(n);
            model_last_d = vecs[v].is_d;
            chk("vec_latency", 64'(n), 64'd1);
            chk("vec_grant", 64'(grant_d), 64'(vecs[v].is_d));
            chk("vec_addr", 64'(bus_target_address), 64'(vecs[v].addr));
            chk("vec_is_write", 64'(bus_is_write), 64'(vecs[v].is_d & vecs[v].wr));
            chk("vec_nbytes", 64'(bus_num_bytes), 64'(vecs[v].nb));
            if (vecs[v].is_d) chk("vec_wdata", 64'(bus_write_value), 64'(vecs[v].wdata));
            finish_txn(vecs[v].lat, vecs[v].rv);
            if (!vecs[v].is_d) last_i_rv = vecs[v].rv;
            i_req = 0; d_req = 0;
            tick();
            chk("vec_idle", 64'({dut.state_q, bus_start_request}), 64'({ST_IDLE, 1'b0}));
            tick();
        end
        chk("i_rdata_hold", 64'(i_rdata), 64'(last_i_rv));

        // Stray bus_request_done in IDLE must be ignored.
        bus_request_done = 1'b1; bus_fetched_value = 32'hBAD0BAD0;
        repeat (2) tick();
        bus_request_done = 1'b0;
        tick();
        chk("stray_done", 64'({dut.state_q, bus_start_request}), 64'({ST_IDLE, 1'b0}));
        chk("stray_rdata", {i_rdata, d_rdata}, {last_i_rv, vecs[4].rv});

        // Reset while BUSY with no done: no pulse, bus released, then D served normally.
        d_req = 1; d_addr = 18'h01234; d_is_write = 0; d_num_bytes = 3'd4;
        wait_start(n);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_last_d = 1'b1;
        chk("midrst_start", 64'(bus_start_request), 64'd0);
        chk("midrst_done", 64'({i_done, d_done}), 64'd0);
        chk("midrst_state", 64'(dut.state_q), 64'(ST_IDLE));
        last_i_rv = '0;
        wait_start(n);
        chk("midrst_regrant", 64'({n[7:0], grant_d}), 64'({8'd1, 1'b1}));
        finish_txn(2, 32'h5A5A0001);
        d_req = 0;
        repeat (2) tick();

        // Simultaneous requests held once each, then permanently re-raised.
        i_addr = 18'h00100; i_num_bytes = 3'd4;
        d_addr = 18'h20020; d_is_write = 1'b1; d_wdata = 32'h77; d_num_bytes = 3'd4;
        d_req = 1; i_req = 1;
        contend(2, 1'b0);
        tick();
        d_req = 1; i_req = 1;
        contend(4, 1'b1);
        i_req = 0; d_req = 0;
        repeat (2) tick();

        // Back-to-back D only: one RELEASE cycle plus the IDLE sampling cycle between bursts.
        d_req = 1;
        contend(3, 1'b1);
        d_req = 0;

        repeat (4) tick();
        chk("i_rdata_final", 64'(i_rdata), 64'(last_i_rv));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
